// File: rtl/memgen_rr_arbiter.sv
// memgen_rr_arbiter
// Single-port behavioural memory shared by NUM_CH requesters through a
// round-robin arbiter. Each channel holds req/wr/addr/wdata until its gnt
// bit is seen. The access happens on that rising edge. Read data comes back
// RD_LAT cycles later, tagged with the issuing channel.
//
// Ports
//   i_clock     rising-edge clock
//   i_reset     asynchronous active-high reset
//   i_chip_en   global enable; low blocks new grants, in-flight reads drain
//   i_req       per-channel request, held until granted
//   i_wr        per-channel op select (1 = write, 0 = read)
//   i_addr      packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   i_wdata     packed write data, channel i at [i*DATA_W +: DATA_W]
//   o_gnt       one-hot combinational grant
//   o_rd_valid  one-cycle pulse per returning read
//   o_rd_ch     channel of the returning read
//   o_rd_data   read data; holds its last value while o_rd_valid is low
`timescale 1ns/1ps
module memgen_rr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_chip_en,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH-1:0]        i_wr,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_wdata,
  output logic [NUM_CH-1:0]        o_gnt,
  output logic                     o_rd_valid,
  output logic [CH_W-1:0]          o_rd_ch,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [CH_W-1:0]   r_ptr;
  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_gnt_any;
  logic              w_wr;
  logic              w_rd_issue;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Stage i of the read pipeline is array index i; the last stage drives
  // the outputs directly.
  logic [RD_LAT-1:0] r_vld_p;
  logic [DATA_W-1:0] r_data_p [RD_LAT];
  logic [CH_W-1:0]   r_ch_p   [RD_LAT];

  // Search starts one past the last granted channel and wraps, so a channel
  // that keeps requesting is served again only after every other requester.
  // Grants are suppressed while reset is asserted so no write can land.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (i_chip_en && !i_reset) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        v_idx = int'(r_ptr) + k;
        if (v_idx >= NUM_CH) v_idx = v_idx - NUM_CH;
        if (!w_gnt_any && i_req[v_idx]) begin
          w_gnt_any    = 1'b1;
          w_gnt_idx    = CH_W'(v_idx);
          w_gnt[v_idx] = 1'b1;
        end
      end
    end
  end

  assign o_gnt      = w_gnt;
  assign w_wr       = i_wr[w_gnt_idx];
  assign w_addr     = i_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_wdata    = i_wdata[w_gnt_idx*DATA_W +: DATA_W];
  assign w_rd_issue = w_gnt_any && !w_wr;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= CH_W'(NUM_CH - 1);
    end else if (w_gnt_any) begin
      r_ptr <= w_gnt_idx;
    end
  end

  // Storage is never reset; only a granted write touches it.
  always_ff @(posedge i_clock) begin
    if (w_gnt_any && w_wr) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  // Grant edge -> stage 0 -> ... -> stage RD_LAT-1 (outputs)
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  // Data stages only load behind a valid, so the output stage holds its
  // last word between responses. Cleared on reset because the last stage
  // is the visible rd_data/rd_ch.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_data_p[i] <= '0;
        r_ch_p[i]   <= '0;
      end
    end else begin
      if (w_rd_issue) begin
        r_data_p[0] <= r_mem[w_addr];
        r_ch_p[0]   <= w_gnt_idx;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        if (r_vld_p[i-1]) begin
          r_data_p[i] <= r_data_p[i-1];
          r_ch_p[i]   <= r_ch_p[i-1];
        end
      end
    end
  end

  assign o_rd_valid = r_vld_p[RD_LAT-1];
  assign o_rd_data  = r_data_p[RD_LAT-1];
  assign o_rd_ch    = r_ch_p[RD_LAT-1];

endmodule

// File: tb/tb_memgen_rr_arbiter.sv
`timescale 1ns/1ps
module tb_memgen_rr_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int NUM_CH = 3;
  localparam int RD_LAT = 3;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     chip_en;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        wr;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        o_gnt;
  logic                     o_rd_valid;
  logic [CH_W-1:0]          o_rd_ch;
  logic [DATA_W-1:0]        o_rd_data;

  always #5 clk = ~clk;

  memgen_rr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .RD_LAT(RD_LAT)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_chip_en (chip_en),
    .i_req     (req),
    .i_wr      (wr),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_gnt     (o_gnt),
    .o_rd_valid(o_rd_valid),
    .o_rd_ch   (o_rd_ch),
    .o_rd_data (o_rd_data)
  );

  // Reference model state
  typedef struct { int due; int ch; logic [DATA_W-1:0] data; } rd_t;
  rd_t               rdq[$];
  logic [DATA_W-1:0] mem_m [int];
  int                last_g;
  int                cyc;
  logic [DATA_W-1:0] exp_data;
  int                exp_ch;
  logic [NUM_CH-1:0] exp_gnt_q;
  int                n_chk;
  int                n_err;

  typedef struct { logic en; logic [NUM_CH-1:0] rq; logic [NUM_CH-1:0] gnt; } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ch(input int c, input logic r, input logic w, input int a,
                        input logic [DATA_W-1:0] d);
    req[c] = r;
    wr[c]  = w;
    addr[c*ADDR_W +: ADDR_W]  = ADDR_W'(a);
    wdata[c*DATA_W +: DATA_W] = d;
  endtask

  // Round robin as a distance rule: the winner is the requester with the
  // smallest forward distance from the channel served last.
  function automatic logic [NUM_CH-1:0] model_gnt();
    int best;
    int bestd;
    int d;
    logic [NUM_CH-1:0] g;
    best  = -1;
    bestd = NUM_CH;
    g     = '0;
    if (chip_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        d = (c - last_g - 1 + 2*NUM_CH) % NUM_CH;
        if (req[c] && d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    if (best >= 0) g[best] = 1'b1;
    return g;
  endfunction

  task automatic check_rd();
    rd_t e;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e = rdq.pop_front();
      check("rd_valid", 64'(o_rd_valid), 64'(1));
      exp_data = e.data;
      exp_ch   = e.ch;
    end else begin
      check("rd_valid", 64'(o_rd_valid), 64'(0));
    end
    check("rd_data", 64'(o_rd_data), 64'(exp_data));
    check("rd_ch", 64'(o_rd_ch), 64'(exp_ch));
  endtask

  // Called at posedge+1 after inputs are driven; returns at the next posedge+1.
  task automatic step(input logic [NUM_CH-1:0] hand, input bit use_hand);
    logic [NUM_CH-1:0] eg;
    rd_t e;
    int a;
    #1;
    eg = model_gnt();
    check("gnt", 64'(o_gnt), 64'(eg));
    if (use_hand) check("gnt_hand", 64'(o_gnt), 64'(hand));
    exp_gnt_q = eg;
    for (int c = 0; c < NUM_CH; c++) begin
      if (eg[c]) begin
        a = int'(addr[c*ADDR_W +: ADDR_W]);
        last_g = c;
        if (wr[c]) begin
          mem_m[a] = wdata[c*DATA_W +: DATA_W];
        end else begin
          e.due  = cyc + RD_LAT;
          e.ch   = c;
          e.data = mem_m.exists(a) ? mem_m[a] : '0;
          rdq.push_back(e);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_rd();
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  // Asserts reset between edges, checks the immediate clear, releases it
  // just after the following edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    req = '0;
    #1;
    check("rst_rd_valid", 64'(o_rd_valid), 64'(0));
    check("rst_rd_data", 64'(o_rd_data), 64'(0));
    check("rst_rd_ch", 64'(o_rd_ch), 64'(0));
    check("rst_gnt", 64'(o_gnt), 64'(0));
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    rdq.delete();
    last_g    = NUM_CH - 1;
    exp_data  = '0;
    exp_ch    = 0;
    exp_gnt_q = '0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    rst = 1'b1; chip_en = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    last_g = NUM_CH - 1; exp_data = '0; exp_ch = 0; exp_gnt_q = '0;

    tbl[0]  = '{1'b1, 3'b011, 3'b001};
    tbl[1]  = '{1'b1, 3'b011, 3'b010};
    tbl[2]  = '{1'b1, 3'b011, 3'b001};
    tbl[3]  = '{1'b1, 3'b111, 3'b010};
    tbl[4]  = '{1'b1, 3'b111, 3'b100};
    tbl[5]  = '{1'b1, 3'b111, 3'b001};
    tbl[6]  = '{1'b0, 3'b111, 3'b000};
    tbl[7]  = '{1'b1, 3'b000, 3'b000};
    tbl[8]  = '{1'b1, 3'b100, 3'b100};
    tbl[9]  = '{1'b1, 3'b100, 3'b100};
    tbl[10] = '{1'b1, 3'b101, 3'b001};
    tbl[11] = '{1'b1, 3'b110, 3'b010};
    tbl[12] = '{1'b1, 3'b001, 3'b001};

    repeat (2) @(posedge clk);
    #1;
    check("init_rd_valid", 64'(o_rd_valid), 64'(0));
    check("init_rd_data", 64'(o_rd_data), 64'(0));
    check("init_rd_ch", 64'(o_rd_ch), 64'(0));
    rst = 1'b0;

    // Basic write then read at the top address
    set_ch(0, 1'b1, 1'b1, 'h3FF, 16'hA5A5);
    step(3'b001, 1'b1);
    set_ch(0, 1'b1, 1'b0, 'h3FF, 16'h0000);
    step(3'b001, 1'b1);
    req = '0;
    for (int i = 0; i < RD_LAT - 1; i++) step('0, 1'b0);
    check("basic_rd_valid", 64'(o_rd_valid), 64'(1));
    check("basic_rd_data", 64'(o_rd_data), 64'(16'hA5A5));
    check("basic_rd_ch", 64'(o_rd_ch), 64'(0));
    idle(2);

    // Preload addresses 0..15 with addr+1 from channel 2
    for (int a = 0; a < 16; a++) begin
      set_ch(2, 1'b1, 1'b1, a, DATA_W'(a + 1));
      step(3'b100, 1'b1);
    end
    idle(1);

    // Table vectors from a fresh pointer; channel c reads address c
    do_reset();
    for (int i = 0; i < 13; i++) begin
      chip_en = tbl[i].en;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, tbl[i].rq[c], 1'b0, c, '0);
      step(tbl[i].gnt, 1'b1);
    end
    chip_en = 1'b1;
    idle(RD_LAT + 1);

    // Fairness: ch0 and ch1 both hold read requests for 6 cycles
    do_reset();
    set_ch(0, 1'b1, 1'b0, 0, '0);
    set_ch(1, 1'b1, 1'b0, 1, '0);
    for (int k = 0; k < 6; k++) step((k % 2 == 0) ? 3'b001 : 3'b010, 1'b1);
    idle(RD_LAT + 1);

    // Back-to-back reads of 0,1,2 holding 1,2,3
    for (int a = 0; a < 3; a++) begin
      set_ch(0, 1'b1, 1'b0, a, '0);
      step(3'b001, 1'b1);
    end
    req = '0;
    check("lat_valid0", 64'(o_rd_valid), 64'(1));
    check("lat_data0", 64'(o_rd_data), 64'(1));
    step('0, 1'b0);
    check("lat_data1", 64'(o_rd_data), 64'(2));
    step('0, 1'b0);
    check("lat_data2", 64'(o_rd_data), 64'(3));
    idle(2);

    // chip_en gating with a read in flight
    set_ch(0, 1'b1, 1'b0, 6, '0);
    step(3'b001, 1'b1);
    req = '0;
    chip_en = 1'b0;
    set_ch(1, 1'b1, 1'b0, 7, '0);
    for (int i = 0; i < 3; i++) step(3'b000, 1'b1);
    chip_en = 1'b1;
    step(3'b010, 1'b1);
    idle(RD_LAT + 1);

    // Read-after-write on address 5
    set_ch(1, 1'b1, 1'b1, 5, 16'h1234);
    step(3'b010, 1'b1);
    req = '0;
    set_ch(0, 1'b1, 1'b0, 5, '0);
    step(3'b001, 1'b1);
    req = '0;
    for (int i = 0; i < RD_LAT - 1; i++) step('0, 1'b0);
    check("raw_valid", 64'(o_rd_valid), 64'(1));
    check("raw_data", 64'(o_rd_data), 64'(16'h1234));
    check("raw_ch", 64'(o_rd_ch), 64'(0));
    idle(2);

    // Reset with two reads in flight
    set_ch(0, 1'b1, 1'b0, 8, '0);
    set_ch(1, 1'b1, 1'b0, 9, '0);
    step(3'b010, 1'b1);
    step(3'b001, 1'b1);
    req = '0;
    do_reset();
    idle(RD_LAT + 2);
    set_ch(0, 1'b1, 1'b0, 0, '0);
    set_ch(1, 1'b1, 1'b0, 1, '0);
    step(3'b001, 1'b1);
    idle(RD_LAT + 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      chip_en = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (exp_gnt_q[c] || (req[c] && $urandom_range(0, 19) == 0)) req[c] = 1'b0;
        if (!req[c] && $urandom_range(0, 9) < 6)
          set_ch(c, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 DATA_W'($urandom));
      end
      step('0, 1'b0);
    end
    chip_en = 1'b1;
    idle(RD_LAT + 2);
    check("final_queue_empty", 64'(rdq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/memgen_rr_arbiter.md
Name: memgen_rr_arbiter

Overview:
Parametrised successor to the fixed 16x1024 MemGen wrapper. It is a single-port synchronous memory shared by NUM_CH requesters through a round-robin arbiter with a per-channel request/grant handshake. Read data returns after a configurable pipeline latency, tagged with the issuing channel. It sits between client engines and the memory macro; storage is a behavioural array in this block.

Parameters:
DATA_W, 16, data word width in bits (1..64)
ADDR_W, 10, address width; depth = 2**ADDR_W words
NUM_CH, 2, number of requesting channels (1..8)
RD_LAT, 1, read latency in cycles from grant edge to rd_valid (1..4)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
chip_en  input  1  global enable; low means no new grants
req  input  NUM_CH  per-channel request, held until granted
wr  input  NUM_CH  per-channel op select: 1 = write, 0 = read
addr  input  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
wdata  input  NUM_CH*DATA_W  packed write data, channel i at [i*DATA_W +: DATA_W]
gnt  output  NUM_CH  one-hot combinational grant; request accepted this cycle
rd_valid  output  1  read data valid, one-cycle pulse per read
rd_ch  output  CH_W  channel of the returning read; CH_W = max(1, clog2(NUM_CH))
rd_data  output  DATA_W  read data

Behaviour:
- Reset (asynchronous assert, released synchronously to clock):
  - rr pointer = NUM_CH-1, so channel 0 has highest priority first.
  - Read pipeline valids cleared; rd_valid=0, rd_ch=0, rd_data=0.
  - Memory contents not reset.
- Grant:
  - gnt is combinational from req, chip_en and the pointer.
  - At most one bit high. Zero when chip_en=0 or req=0.
  - Priority order: pointer+1, pointer+2, ... modulo NUM_CH.
  - On a grant edge the pointer loads the granted index; otherwise it holds.
  - A channel that keeps req high is skipped until every other requesting channel has been served once. No starvation.
- Handshake:
  - Transfer occurs on the rising edge where gnt[i]=1.
  - The requester must hold req/wr/addr/wdata stable until then. It may drop or change them the cycle after.
  - Dropping req before grant is legal; nothing is recorded.
- Write: the array word at addr is updated at the grant edge. No read response is produced.
- Read:
  - The array is sampled at the grant edge. Only one access per cycle, so there is no same-cycle read/write conflict.
  - The word plus the channel index enter an RD_LAT-stage valid pipeline.
  - rd_valid pulses exactly RD_LAT cycles after the grant edge, with rd_data/rd_ch.
  - Responses return in grant order. Throughput is one access per cycle.
- Read-after-write: a read granted in any cycle after a write to the same address returns the new data.
- rd_data/rd_ch hold their last value when rd_valid=0.
- chip_en low:
  - Blocks new grants only.
  - In-flight reads keep draining.
  - The pointer holds.
- Reset mid-operation: in-flight reads are discarded with no rd_valid. Writes already granted remain in memory.
- NUM_CH=1: the arbiter degenerates to gnt = req & chip_en; rd_ch = 0.
- Address wrap: the full ADDR_W is decoded; there are no out-of-range addresses.

Test Plan:
- Basic write/read:
  - Stimulus: RD_LAT=1. ch0 writes 16'hA5A5 to addr 10'h3FF, then reads it.
  - Required: gnt[0] high each request cycle. rd_valid one cycle after the read grant, rd_data=16'hA5A5, rd_ch=0.
- Round-robin fairness:
  - Stimulus: NUM_CH=2. Both channels hold read requests for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1. Each rd_ch sequence matches, with no gaps.
- Latency sweep:
  - Stimulus: RD_LAT=3. Back-to-back reads of addrs 0,1,2, preloaded with 1,2,3.
  - Required: rd_valid in cycles G+3, G+4, G+5 with rd_data 1,2,3.
- chip_en gating:
  - Stimulus: a read is in flight with RD_LAT=2, then chip_en drops for 3 cycles while ch1 requests.
  - Required: the in-flight read still returns on time. gnt stays 0 during chip_en low. ch1 is granted the first cycle chip_en returns.
- Read-after-write:
  - Stimulus: ch1 writes 16'h1234 to addr 5 in cycle T; ch0 reads addr 5 in T+1.
  - Required: rd_data=16'h1234, rd_ch=0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between clock edges while 2 reads are in flight (RD_LAT=4).
  - Required: outputs go to 0 immediately and no rd_valid pulses follow. After release, the first grant goes to ch0 when both channels request.
